// File: rtl/proc_check_unit.sv
// proc_check_unit: counts enabled run cycles, then checks a table of expected
//   (register, value) pairs against the live regfile; traces writebacks while running.
// Latency: checking starts after CYCLE_LIMIT enabled cycles, 2 cycles per table entry.
// Backpressure: none on writeback; trace FIFO drops new entries when full (sticky overflow).

// Generic show-ahead FIFO: head entry visible whenever valid=1.
// Latency: push visible after 1 edge when empty; pop-to-next-head 1 edge.
// Backpressure: push while full without pop is dropped and flagged in overflow.
module proc_check_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // if a pop frees the head slot on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = mem[rd_ptr];
  assign valid     = !empty;

  // Pointer, occupancy and sticky overflow tracking; pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

module proc_check_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int NUM_CHECKS       = 32,
  parameter int CHECK_ADDR_WIDTH = 6,
  parameter int CYCLE_LIMIT      = 1000,
  parameter int CYCLE_WIDTH      = 16,
  parameter int TRACE_DEPTH      = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        wb_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0]   wb_write_reg,
  input  logic [DATA_WIDTH-1:0]       wb_write_data,
  output logic [CHECK_ADDR_WIDTH-1:0] exp_addr,
  input  logic [REG_ADDR_WIDTH-1:0]   exp_reg,
  input  logic [DATA_WIDTH-1:0]       exp_value,
  output logic [REG_ADDR_WIDTH-1:0]   chk_read_reg,
  input  logic [DATA_WIDTH-1:0]       chk_read_data,
  input  logic                        trace_pop,
  output logic                        trace_valid,
  output logic [REG_ADDR_WIDTH-1:0]   trace_reg,
  output logic [DATA_WIDTH-1:0]       trace_data,
  output logic                        trace_overflow,
  output logic [CYCLE_WIDTH-1:0]      cycle_count,
  output logic                        done,
  output logic                        pass,
  output logic [CHECK_ADDR_WIDTH:0]   error_count,
  output logic [CHECK_ADDR_WIDTH-1:0] fail_index,
  output logic [DATA_WIDTH-1:0]       fail_value
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FETCH   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CYCLE_WIDTH-1:0]      CYCLE_LAST = CYCLE_WIDTH'(CYCLE_LIMIT - 1);
  localparam logic [CHECK_ADDR_WIDTH-1:0] IDX_LAST   = CHECK_ADDR_WIDTH'(NUM_CHECKS - 1);

  state_t                      state;
  state_t                      state_nxt;
  logic [CHECK_ADDR_WIDTH-1:0] idx;
  logic                        run_last;
  logic                        mismatch;
  logic                        trace_push;

  // The table ROM is addressed by the current index; it answers one cycle
  // later, which is exactly when the FSM sits in COMPARE.
  assign exp_addr     = idx;
  assign chk_read_reg = exp_reg;

  assign done = (state == DONE);
  assign pass = done && (error_count == '0);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state logic plus per-cycle decode strobes.
  always_comb begin
    state_nxt  = state;
    run_last   = 1'b0;
    mismatch   = 1'b0;
    trace_push = 1'b0;
    case (state)
      RUN: begin
        trace_push = wb_write_enable && (wb_write_reg != '0);
        run_last   = enable && (cycle_count == CYCLE_LAST);
        if (run_last) state_nxt = FETCH;
      end
      FETCH: begin
        state_nxt = COMPARE;
      end
      COMPARE: begin
        mismatch = (chk_read_data != exp_value);
        if (idx == IDX_LAST) state_nxt = DONE;
        else                 state_nxt = FETCH;
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Run-cycle counter, table index and check results; a reset in any state
  // throws away any partially accumulated result.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= '0;
      idx         <= '0;
      error_count <= '0;
      fail_index  <= '0;
      fail_value  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (enable) cycle_count <= cycle_count + CYCLE_WIDTH'(1);
          if (run_last) idx <= '0;
        end
        COMPARE: begin
          if (mismatch) begin
            error_count <= error_count + (CHECK_ADDR_WIDTH + 1)'(1);
            // Only the first failing entry is recorded.
            if (error_count == '0) begin
              fail_index <= idx;
              fail_value <= chk_read_data;
            end
          end
          if (idx != IDX_LAST) idx <= idx + CHECK_ADDR_WIDTH'(1);
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

  // Writeback trace storage, entries packed as {register, data}.
  proc_check_fifo #(
    .WIDTH (REG_ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (trace_push),
    .push_data ({wb_write_reg, wb_write_data}),
    .pop       (trace_pop),
    .head_data ({trace_reg, trace_data}),
    .valid     (trace_valid),
    .overflow  (trace_overflow)
  );

endmodule

// File: doc/proc_check_unit.md
# proc_check_unit

Synthesizable, parametrised self-check unit for the pipelined processor skeleton. It counts enabled run cycles up to a limit, then walks a table of expected (register, value) pairs. Each entry is compared against the live register file, and the unit reports the error count, the first failing entry and a pass flag. While running, it also captures regfile writebacks into a show-ahead trace FIFO. It sits beside the processor and regfile in the skeleton, tapping the writeback port and borrowing one regfile read port after the run.

## Interface
Parameters:
- DATA_WIDTH, 32, register/data width
- REG_ADDR_WIDTH, 5, register index width
- NUM_CHECKS, 32, number of expected-table entries (>=1)
- CHECK_ADDR_WIDTH, 6, table index width, 2^CHECK_ADDR_WIDTH >= NUM_CHECKS
- CYCLE_LIMIT, 1000, enabled run cycles before checking (>=1)
- CYCLE_WIDTH, 16, cycle counter width, 2^CYCLE_WIDTH > CYCLE_LIMIT
- TRACE_DEPTH, 16, trace FIFO entries, power of two >=2

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  run-cycle count enable
- wb_write_enable  in  1  processor regfile write strobe
- wb_write_reg  in  REG_ADDR_WIDTH  writeback register index
- wb_write_data  in  DATA_WIDTH  writeback data
- exp_addr  out  CHECK_ADDR_WIDTH  expected-table read address
- exp_reg  in  REG_ADDR_WIDTH  table register field, valid 1 cycle after exp_addr (synchronous ROM)
- exp_value  in  DATA_WIDTH  table value field, same timing as exp_reg
- chk_read_reg  out  REG_ADDR_WIDTH  regfile read index, combinational from exp_reg
- chk_read_data  in  DATA_WIDTH  regfile read data, combinational (same cycle)
- trace_pop  in  1  consume trace head
- trace_valid  out  1  trace FIFO non-empty
- trace_reg  out  REG_ADDR_WIDTH  head entry register
- trace_data  out  DATA_WIDTH  head entry data
- trace_overflow  out  1  sticky: an entry was dropped
- cycle_count  out  CYCLE_WIDTH  enabled run cycles counted
- done  out  1  check sequence finished
- pass  out  1  done and error_count==0
- error_count  out  CHECK_ADDR_WIDTH+1  mismatching entries
- fail_index  out  CHECK_ADDR_WIDTH  first mismatching entry index
- fail_value  out  DATA_WIDTH  regfile value read at first mismatch

## Operation
- Reset behaviour:
  - State becomes RUN.
  - All counters, cycle_count, error_count, fail_index, fail_value, exp_addr, done, pass and trace_overflow become 0.
  - The FIFO becomes empty, so trace_valid is 0.
  - trace_reg and trace_data are don't-care while trace_valid is 0.
- States:
  - RUN: cycle_count increments on each edge with enable=1. On the edge where cycle_count==CYCLE_LIMIT-1 and enable=1, cycle_count reaches CYCLE_LIMIT and the state moves to FETCH with idx=0. cycle_count then holds.
  - FETCH: exp_addr=idx. Always moves to COMPARE.
  - COMPARE: exp_reg and exp_value are valid, and chk_read_reg=exp_reg.
    - A mismatch is chk_read_data !== exp_value.
    - On a mismatch, error_count increments. If error_count was 0, fail_index<=idx and fail_value<=chk_read_data.
    - If idx==NUM_CHECKS-1 the state moves to DONE; otherwise idx increments and the state moves to FETCH.
  - DONE: done=1 and pass=(error_count==0). The unit holds until reset; enable and wb_* are ignored.
- Later mismatches never overwrite fail_index or fail_value.
- error_count cannot overflow, because its width covers NUM_CHECKS.
- Trace FIFO capture:
  - An entry is pushed on an edge in state RUN with wb_write_enable=1 and wb_write_reg!=0. Writes to r0 are never traced.
  - Capture is independent of enable.
- Trace FIFO output:
  - The FIFO is show-ahead: trace_reg and trace_data always show the oldest entry.
  - A pop happens on an edge with trace_pop=1 and trace_valid=1. trace_pop while empty is ignored.
  - Pops are allowed in every state.
- Trace FIFO boundary cases:
  - Full with push and no pop: the new entry is dropped and trace_overflow<=1. trace_overflow stays set until reset.
  - Full with simultaneous push and pop: both happen, the count is unchanged, and overflow is not set.
  - Empty with simultaneous push and pop: the pop is ignored and the push is stored.
  - Read and write pointers wrap modulo TRACE_DEPTH.
- Reset mid-operation, in any state: the unit returns to the reset values above on that edge, and any partial check result is discarded.

## Timing
- With reset released before edge 1 and enable=1 continuously:
  - FETCH is entered after edge CYCLE_LIMIT.
  - done rises after edge CYCLE_LIMIT+2*NUM_CHECKS.
- Each check costs exactly 2 cycles. There is no stall input.
- error_count, fail_index and fail_value update on the COMPARE edge and are final once done=1.
- A trace entry pushed on edge N is visible (trace_valid=1) after edge N if the FIFO was empty.
- Pop-to-next-head latency is 1 edge.
- FIFO occupancy range: 0..TRACE_DEPTH.

## Test plan
- Table matching regfile, CYCLE_LIMIT=10, NUM_CHECKS=4, enable=1 -> done rises after edge 18, pass=1, error_count=0.
- Entries 1 and 3 mismatched (entry 1: expect r2=5, regfile 7) -> error_count=2, fail_index=1, fail_value=7, pass=0.
- enable held low for 5 cycles mid-run -> cycle_count pauses and done rises after edge 23.
- TRACE_DEPTH=4: write r1..r6 without pop -> trace_overflow=1 and entries r1..r4 remain. Next, 4 pops -> trace_valid=0, and a fifth pop is ignored.
- Full FIFO with push and pop on the same edge -> count stays 4, the head advances, the new entry is stored at the tail, and overflow is not set. A write to r0 -> nothing is pushed.
- reset asserted during COMPARE of entry 2 -> the next cycle shows state RUN with done=0, error_count=0 and cycle_count=0. A rerun produces identical results.
